// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Purpose: shares one single-port on-chip RAM between two requesters (m0, m1).
// Grants are decided combinationally in the cycle a request is presented.
// Simultaneous requests alternate between the ports by looking at the last
// winner. Writes complete in the grant cycle. Reads return exactly one cycle
// after the grant, on the port that issued them.
//
// Optional feature: define ONCHIP_MEM_ARB_RANGE_CHECK_EN to block accesses at
// word addresses >= DEPTH. A blocked write is dropped. A blocked read
// returns 32'hDEADBEEF one cycle later.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   mX_address/byteenable/writedata   requester command fields (X = 0, 1)
//   mX_read, mX_write                 requester strobes (both high = write)
//   mX_waitrequest                    request not accepted this cycle
//   mX_readdata, mX_readdatavalid     read return (data is 0 when not valid)
//   mem_address/byteenable/writedata  RAM command fields
//   mem_chipselect, mem_write         RAM access strobes
//   mem_clken                         RAM clock enable (high out of reset)
//   mem_readdata                      RAM output, one cycle after the address
//   hold                              blocks new grants while high
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 44800
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  input  logic              hold
);

  // The RAM cannot hold more words than the address bus can reach.
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("onchip_mem_arbiter: DEPTH does not fit in ADDR_W address bits");
  end

  logic              m0_act, m1_act;
  logic              gnt_vld;
  logic              gnt_id;        // 0 = m0, 1 = m1
  logic              gnt_wr, gnt_rd;
  logic [ADDR_W-1:0] gnt_addr;
  logic [3:0]        gnt_be;
  logic [31:0]       gnt_wdata;
  logic [31:0]       rd_data;

  logic              last_grant_q, last_grant_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_id_q, rd_id_d;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;

  assign m0_act = m0_read | m0_write;
  assign m1_act = m1_read | m1_write;

  // Arbitration. reset_n gates the grant so that nothing reaches the RAM
  // while the block is held in reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (reset_n && !hold) begin
      if (m0_act && m1_act) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (m0_act) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (m1_act) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign gnt_addr  = gnt_id ? m1_address    : m0_address;
  assign gnt_be    = gnt_id ? m1_byteenable : m0_byteenable;
  assign gnt_wdata = gnt_id ? m1_writedata  : m0_writedata;
  // Write takes priority when a port raises read and write together.
  assign gnt_wr    = gnt_vld & (gnt_id ? m1_write : m0_write);
  assign gnt_rd    = gnt_vld & ~gnt_wr;

  assign m0_waitrequest = ~reset_n | (m0_act & ~(gnt_vld & ~gnt_id));
  assign m1_waitrequest = ~reset_n | (m1_act & ~(gnt_vld &  gnt_id));

  // Command fields follow the granted port. They keep their last value when
  // there is no grant so the RAM address bus does not toggle needlessly.
  assign mem_address    = gnt_vld ? gnt_addr  : addr_q;
  assign mem_byteenable = gnt_vld ? gnt_be    : be_q;
  assign mem_writedata  = gnt_vld ? gnt_wdata : wdata_q;
  assign mem_clken      = reset_n;

`ifdef ONCHIP_MEM_ARB_RANGE_CHECK_EN
  logic gnt_oob;
  logic rd_oob_q, rd_oob_d;

  assign gnt_oob        = (32'(gnt_addr) >= 32'(DEPTH));
  assign mem_chipselect = gnt_vld & ~gnt_oob;
  assign mem_write      = gnt_wr  & ~gnt_oob;
  assign rd_oob_d       = gnt_rd  &  gnt_oob;
  assign rd_data        = rd_oob_q ? 32'hDEADBEEF : mem_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_oob_q <= 1'b0;
    else          rd_oob_q <= rd_oob_d;
  end
`else
  assign mem_chipselect = gnt_vld;
  assign mem_write      = gnt_wr;
  assign rd_data        = mem_readdata;
`endif

  assign last_grant_d = gnt_vld ? gnt_id : last_grant_q;
  assign rd_pend_d    = gnt_rd;
  assign rd_id_d      = gnt_rd ? gnt_id : rd_id_q;

  // Control state. Reset clears any pending read return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_id_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_id_q      <= rd_id_d;
    end
  end

  // Held copy of the last granted command fields.
  always_ff @(posedge clk) begin
    if (gnt_vld) begin
      addr_q  <= gnt_addr;
      be_q    <= gnt_be;
      wdata_q <= gnt_wdata;
    end
  end

  assign m0_readdatavalid = rd_pend_q & ~rd_id_q;
  assign m1_readdatavalid = rd_pend_q &  rd_id_q;
  assign m0_readdata      = m0_readdatavalid ? rd_data : 32'h0;
  assign m1_readdata      = m1_readdatavalid ? rd_data : 32'h0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;
  logic        hold;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(16), .DEPTH(44800)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .hold(hold)
  );

  // Single-port RAM with byte lanes and one-cycle read latency.
  logic [31:0] ram [0:65535];
  logic [31:0] rdq;
  assign mem_readdata = rdq;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        rdq <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic m0_cmd(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask

  task automatic m1_cmd(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
  endtask

  initial begin
    reset_n = 0; hold = 0;
    m0_cmd(1, 0, 16'h0001, 32'h0, 4'hF);
    m1_cmd(0, 1, 16'h0002, 32'h0, 4'hF);
    #2;
    // Reset values, with requests present
    chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    chk("rst_cs",      32'(mem_chipselect), 32'd0);
    chk("rst_wr",      32'(mem_write),      32'd0);
    chk("rst_clken",   32'(mem_clken),      32'd0);
    chk("rst_m0_vld",  32'(m0_readdatavalid), 32'd0);
    chk("rst_m1_vld",  32'(m1_readdatavalid), 32'd0);
    chk("rst_m0_rd",   m0_readdata, 32'h0);
    chk("rst_m1_rd",   m1_readdata, 32'h0);
    idle();
    step(); step();
    reset_n = 1;
    #1;
    chk("idle_clken",  32'(mem_clken),      32'd1);
    chk("idle_m0_wait",32'(m0_waitrequest), 32'd0);
    chk("idle_m1_wait",32'(m1_waitrequest), 32'd0);
    chk("idle_cs",     32'(mem_chipselect), 32'd0);

    // m0 write then read back
    step();
    m0_cmd(0, 1, 16'h0010, 32'h12345678, 4'hF);
    #1;
    chk("w_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("w_cs",      32'(mem_chipselect), 32'd1);
    chk("w_wr",      32'(mem_write),      32'd1);
    chk("w_addr",    32'(mem_address),    32'h10);
    chk("w_data",    mem_writedata,       32'h12345678);
    step();
    m0_cmd(1, 0, 16'h0010, 32'h0, 4'hF);
    #1;
    chk("r_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("r_cs",      32'(mem_chipselect), 32'd1);
    chk("r_wr",      32'(mem_write),      32'd0);
    chk("r_noearly", 32'(m0_readdatavalid), 32'd0);
    step();
    idle();
    #1;
    chk("r_m0_vld",  32'(m0_readdatavalid), 32'd1);
    chk("r_m0_data", m0_readdata, 32'h12345678);
    chk("r_m1_vld",  32'(m1_readdatavalid), 32'd0);
    chk("r_m1_data", m1_readdata, 32'h0);
    step();
    chk("r_vld_once", 32'(m0_readdatavalid), 32'd0);
    chk("r_data_zero", m0_readdata, 32'h0);

    // Preload words for the alternating-read test (read+write = write)
    m0_cmd(1, 1, 16'h0020, 32'hA0A0A0A0, 4'hF);
    #1;
    chk("rw_is_wr", 32'(mem_write), 32'd1);
    step();
    m0_cmd(0, 1, 16'h0021, 32'hB1B1B1B1, 4'hF);
    #1;
    chk("rw_no_vld", 32'(m0_readdatavalid), 32'd0);
    step();

    // Reset pulsed the cycle after a granted read
    m0_cmd(1, 0, 16'h0010, 32'h0, 4'hF);
    step();
    idle();
    reset_n = 0;
    #1;
    chk("mid_rst_vld",  32'(m0_readdatavalid), 32'd0);
    chk("mid_rst_data", m0_readdata, 32'h0);
    chk("mid_rst_wait", 32'(m0_waitrequest), 32'd1);
    chk("mid_rst_cs",   32'(mem_chipselect), 32'd0);
    chk("mid_rst_clk",  32'(mem_clken), 32'd0);
    step();
    reset_n = 1;
    #1;
    chk("post_rst_vld", 32'(m0_readdatavalid), 32'd0);
    step();
    chk("post_rst_vld2", 32'(m0_readdatavalid), 32'd0);

    // Both ports read continuously: m0, m1, m0, m1
    m0_cmd(1, 0, 16'h0020, 32'h0, 4'hF);
    m1_cmd(1, 0, 16'h0021, 32'h0, 4'hF);
    #1;
    chk("alt1_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("alt1_m1_wait", 32'(m1_waitrequest), 32'd1);
    chk("alt1_addr",    32'(mem_address), 32'h20);
    step();
    chk("alt2_m0_wait", 32'(m0_waitrequest), 32'd1);
    chk("alt2_m1_wait", 32'(m1_waitrequest), 32'd0);
    chk("alt2_addr",    32'(mem_address), 32'h21);
    chk("alt2_m0_vld",  32'(m0_readdatavalid), 32'd1);
    chk("alt2_m0_data", m0_readdata, 32'hA0A0A0A0);
    chk("alt2_m1_vld",  32'(m1_readdatavalid), 32'd0);
    step();
    chk("alt3_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("alt3_m1_vld",  32'(m1_readdatavalid), 32'd1);
    chk("alt3_m1_data", m1_readdata, 32'hB1B1B1B1);
    chk("alt3_m0_vld",  32'(m0_readdatavalid), 32'd0);
    step();
    chk("alt4_m1_wait", 32'(m1_waitrequest), 32'd0);
    chk("alt4_m0_vld",  32'(m0_readdatavalid), 32'd1);
    chk("alt4_m0_data", m0_readdata, 32'hA0A0A0A0);
    step();
    idle();
    #1;
    chk("alt5_m1_vld",  32'(m1_readdatavalid), 32'd1);
    chk("alt5_m1_data", m1_readdata, 32'hB1B1B1B1);
    step();
    chk("alt6_vld", 32'(m0_readdatavalid | m1_readdatavalid), 32'd0);

    // m1 partial write
    m1_cmd(0, 1, 16'h0030, 32'h11223344, 4'hF);
    step();
    m1_cmd(0, 1, 16'h0030, 32'hAABBCCDD, 4'h3);
    #1;
    chk("be_m1_wait", 32'(m1_waitrequest), 32'd0);
    chk("be_be",      32'(mem_byteenable), 32'h3);
    step();
    m1_cmd(1, 0, 16'h0030, 32'h0, 4'hF);
    step();
    idle();
    #1;
    chk("be_m1_vld",  32'(m1_readdatavalid), 32'd1);
    chk("be_m1_data", m1_readdata, 32'h1122CCDD);
    step();

    // hold blocks grants; release grants in the same cycle
    hold = 1;
    m0_cmd(1, 0, 16'h0010, 32'h0, 4'hF);
    #1;
    chk("hold_m0_wait", 32'(m0_waitrequest), 32'd1);
    chk("hold_cs",      32'(mem_chipselect), 32'd0);
    step();
    chk("hold_m0_wait2", 32'(m0_waitrequest), 32'd1);
    chk("hold_no_vld",   32'(m0_readdatavalid), 32'd0);
    hold = 0;
    #1;
    chk("rel_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("rel_cs",      32'(mem_chipselect), 32'd1);
    step();
    idle();
    #1;
    chk("rel_m0_vld",  32'(m0_readdatavalid), 32'd1);
    chk("rel_m0_data", m0_readdata, 32'h12345678);
    step();

    // hold rises right after a granted read: data still returns
    m1_cmd(1, 0, 16'h0021, 32'h0, 4'hF);
    step();
    hold = 1;
    #1;
    chk("hr_m1_vld",  32'(m1_readdatavalid), 32'd1);
    chk("hr_m1_data", m1_readdata, 32'hB1B1B1B1);
    chk("hr_m1_wait", 32'(m1_waitrequest), 32'd1);
    chk("hr_cs",      32'(mem_chipselect), 32'd0);
    step();
    chk("hr_vld_once", 32'(m1_readdatavalid), 32'd0);
    hold = 0;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: word-address width of both requester ports and the memory port.
REQ-002 SHALL have parameter DEPTH, default 44800: number of 32-bit words implemented in the memory.
REQ-003 SHALL have port clk  in  1: the single clock; all registers update on its rising edge.
REQ-004 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have ports m0_address, m1_address  in  ADDR_W: requester word addresses.
REQ-006 SHALL have ports m0_byteenable, m1_byteenable  in  4: write byte lanes.
REQ-007 SHALL have ports m0_read, m1_read, m0_write, m1_write  in  1: access requests.
REQ-008 SHALL have ports m0_writedata, m1_writedata  in  32: write data.
REQ-009 SHALL have ports m0_waitrequest, m1_waitrequest  out  1: request not accepted this cycle.
REQ-010 SHALL have ports m0_readdata, m1_readdata  out  32; m0_readdatavalid, m1_readdatavalid  out  1: read return.
REQ-011 SHALL have ports mem_address  out  ADDR_W; mem_byteenable  out  4; mem_writedata  out  32; mem_chipselect, mem_write, mem_clken  out  1: single-port RAM drive.
REQ-012 SHALL have port mem_readdata  in  32: RAM output, valid one cycle after the address is presented.
REQ-013 SHALL have port hold  in  1: when high, no new grants are issued.

Function
REQ-014 A requester is active when its read or write is high; read and write both high on one port SHALL be treated as write.
REQ-015 Grant SHALL be combinational in the current cycle: only one active -> that one; both active -> the port not recorded in register last_grant; neither or hold=1 -> no grant.
REQ-016 last_grant SHALL update to the granted port on every cycle with a grant and hold otherwise.
REQ-017 Granted port's waitrequest SHALL be 0; every other active port's waitrequest SHALL be 1; an idle port's waitrequest SHALL be 0.
REQ-018 On grant: mem_address, mem_byteenable, mem_writedata SHALL mirror the granted port, mem_chipselect=1, mem_write=1 only for a granted write.
REQ-019 No grant: mem_chipselect=0, mem_write=0, other memory outputs don't-care but held at last value.
REQ-020 mem_clken SHALL be 1 whenever reset_n is high.
REQ-021 Read latency SHALL be exactly 1 cycle: cycle after a granted read, the granted port's readdatavalid=1 and readdata=mem_readdata; tracked by registered rd_pend and rd_id.
REQ-022 readdatavalid SHALL be 1 for exactly one cycle per granted read; the non-owning port's readdatavalid SHALL be 0; readdata SHALL be 0 when readdatavalid is 0.
REQ-023 Back-to-back granted reads SHALL each return one cycle after grant with no bubble, including alternating ports.
REQ-024 A read granted in the cycle hold rises SHALL still return its data in the next cycle.
REQ-025 Writes SHALL complete in the grant cycle; no response is generated.

Reset
REQ-026 While reset_n=0: last_grant=1 (so m0 wins first tie), rd_pend=0, all readdatavalid=0, readdata=0, mem_chipselect=0, mem_write=0, mem_clken=0, both waitrequest=1.
REQ-027 Reset asserted mid-read SHALL discard the pending return; no readdatavalid after reset release.

Configuration
REQ-028 With macro ONCHIP_MEM_ARB_RANGE_CHECK_EN defined: granted access with address >= DEPTH SHALL keep mem_chipselect=0; such a write is dropped; such a read returns readdatavalid=1 with readdata=32'hDEADBEEF one cycle later; arbitration and last_grant unchanged.
REQ-029 Without ONCHIP_MEM_ARB_RANGE_CHECK_EN: no address check; all granted accesses reach memory unmodified.

Verification
REQ-030 Reset release, m0 write addr 0x0010 data 0x12345678 be 0xF, then m0 read 0x0010 -> m0_waitrequest=0 both cycles, m0_readdatavalid=1 one cycle later, readdata=0x12345678.
REQ-031 m0 and m1 read together continuously for 4 cycles first after reset -> grants m0,m1,m0,m1; each port's waitrequest alternates; valids alternate with 1-cycle latency.
REQ-032 m1 write be=0x3 data 0xAABBCCDD to word holding 0x11223344, then read -> 0x1122CCDD.
REQ-033 hold=1 while m0 reads -> m0_waitrequest=1, mem_chipselect=0; release -> read granted same cycle, data next cycle.
REQ-034 reset_n pulsed low the cycle after a granted read -> no readdatavalid afterwards, all outputs at reset values.
REQ-035 With ONCHIP_MEM_ARB_RANGE_CHECK_EN, m1 read addr 44800 -> mem_chipselect=0, m1_readdata=0xDEADBEEF with valid next cycle; write to 44800 leaves memory unchanged.
